// File: rtl/microseq.sv
// microseq: micro-PC sequencer for the multicycle ARM core, choosing the next control-store
// address from the sequencing field, Op/Funct dispatch and memory wait, with retire/error tracking.
module microseq #(
    parameter int UPC_W   = 5,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [2:0]       seq_ctl,
    input  logic [UPC_W-1:0] jump_addr,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic [UPC_W-1:0] upc,
    output logic             stall,
    output logic             instr_done,
    output logic             dispatch_err,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [UPC_W-1:0] FETCH  = '0;
    localparam logic [UPC_W-1:0] MEMADR = UPC_W'(2);
    localparam logic [UPC_W-1:0] MEMRD  = UPC_W'(3);
    localparam logic [UPC_W-1:0] MEMWR  = UPC_W'(5);
    localparam logic [UPC_W-1:0] EXECR  = UPC_W'(6);
    localparam logic [UPC_W-1:0] EXECI  = UPC_W'(7);
    localparam logic [UPC_W-1:0] BRANCH = UPC_W'(9);
    logic [UPC_W-1:0]  upc_q, upc_d, seq_upc, disp1, disp2;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q;
    logic              done_q, done_d, disp_err_q, disp_err_d, bus_err_q, bus_err_d, timeout;
    assign stall = mem_req & ~mem_ready & ~reset;
    always_comb begin
        disp1      = Op == 2'b00 ? (Funct[5] ? EXECI : EXECR) : Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : FETCH;
        disp2      = Funct[0] ? MEMRD : MEMWR;
        seq_upc    = seq_ctl == 3'b000 ? upc_q + 1'b1 : seq_ctl == 3'b001 ? jump_addr :
                     seq_ctl == 3'b010 ? disp1 : seq_ctl == 3'b011 ? disp2 : FETCH;
        timeout    = stall && wait_q == WAIT_LAST;
        upc_d      = timeout ? FETCH : stall ? upc_q : seq_upc;
        wait_d     = stall && !timeout ? wait_q + 1'b1 : '0;
        // Only deliberate returns to FETCH retire; illegal dispatch and timeout do not.
        done_d     = !stall && (seq_ctl[2] || (seq_ctl == 3'b001 && jump_addr == FETCH));
        disp_err_d = disp_err_q | (!stall && seq_ctl == 3'b010 && Op == 2'b11);
        bus_err_d  = bus_err_q | timeout;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            upc_q      <= '0;
            wait_q     <= '0;
            done_q     <= 1'b0;
            disp_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            retired_q  <= '0;
        end else begin
            upc_q      <= upc_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            disp_err_q <= disp_err_d;
            bus_err_q  <= bus_err_d;
            retired_q  <= retired_q + CNT_W'(done_d);
        end
    end
    assign upc          = upc_q;
    assign instr_done   = done_q;
    assign dispatch_err = disp_err_q;
    assign bus_err      = bus_err_q;
    assign retired      = retired_q;
endmodule

// File: tb/tb_microseq.sv
// tb_microseq: table-driven, hand-sequenced and randomized checks of microseq against a reference model.
module tb_microseq;
    localparam int TIMEOUT = 15;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [2:0] seq_ctl = '0;
    logic [4:0] jump_addr = '0;
    logic       mem_req = 1'b0, mem_ready = 1'b0;
    logic [4:0] upc;
    logic       stall, instr_done, dispatch_err, bus_err;
    logic [3:0] retired;
    int checks = 0, errors = 0;
    int m_upc = 0, m_wait = 0, m_bus = 0, m_disp = 0, m_ret = 0, m_done = 0;

    microseq #(.UPC_W(5), .TIMEOUT(TIMEOUT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .seq_ctl(seq_ctl), .jump_addr(jump_addr),
        .mem_req(mem_req), .mem_ready(mem_ready), .upc(upc), .stall(stall), .instr_done(instr_done),
        .dispatch_err(dispatch_err), .bus_err(bus_err), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst; logic [1:0] op; logic [5:0] fn; logic [2:0] sq; logic [4:0] ja; logic rq; logic rd;
        int e_upc; int e_done; int e_stall;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic [1:0] op, input logic [5:0] fn, input logic [2:0] sq,
                               input logic [4:0] ja, input logic rq, input logic rd, input int eu, input int ed, input int es);
        vec_t r;
        r.rst = rst; r.op = op; r.fn = fn; r.sq = sq; r.ja = ja; r.rq = rq; r.rd = rd;
        r.e_upc = eu; r.e_done = ed; r.e_stall = es;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model by the architectural rules, compares everything.
    task automatic cyc(input logic rst, input logic [1:0] op, input logic [5:0] fn, input logic [2:0] sq,
                       input logic [4:0] ja, input logic rq, input logic rd);
        int ms;
        reset = rst; Op = op; Funct = fn; seq_ctl = sq; jump_addr = ja; mem_req = rq; mem_ready = rd;
        #1;
        ms = (rq && !rd && !rst) ? 1 : 0;
        chk("stall", int'(stall), ms);
        m_done = 0;
        if (rst) begin
            m_upc = 0; m_wait = 0; m_bus = 0; m_disp = 0; m_ret = 0;
        end else if (ms == 1) begin
            if (m_wait == TIMEOUT - 1) begin m_upc = 0; m_bus = 1; m_wait = 0; end
            else m_wait++;
        end else begin
            m_wait = 0;
            case (sq)
                3'd0: m_upc = (m_upc + 1) % 32;
                3'd1: begin m_upc = int'(ja); m_done = (ja == 0) ? 1 : 0; end
                3'd2: case (op)
                    2'd0: m_upc = fn[5] ? 7 : 6;
                    2'd1: m_upc = 2;
                    2'd2: m_upc = 9;
                    default: begin m_upc = 0; m_disp = 1; end
                endcase
                3'd3: m_upc = fn[0] ? 3 : 5;
                default: begin m_upc = 0; m_done = 1; end
            endcase
            if (m_done == 1) m_ret = (m_ret + 1) % 16;
        end
        @(posedge clk);
        #1;
        chk("upc", int'(upc), m_upc);
        chk("instr_done", int'(instr_done), m_done);
        chk("dispatch_err", int'(dispatch_err), m_disp);
        chk("bus_err", int'(bus_err), m_bus);
        chk("retired", int'(retired), m_ret);
    endtask

    task automatic go(input logic [2:0] sq, input logic [1:0] op, input logic [5:0] fn, input logic [4:0] ja);
        cyc(1'b0, op, fn, sq, ja, 1'b0, 1'b0);
    endtask

    task automatic to_memrd();
        go(3'd4, 2'd0, 6'd0, 5'd0);
        go(3'd0, 2'd0, 6'd0, 5'd0);
        go(3'd2, 2'd1, 6'd1, 5'd0);
        go(3'd3, 2'd1, 6'd1, 5'd0);
    endtask

    initial begin
        int r0;
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 2, 0, 0, 0, 6, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 8, 0, 0, 8, 0, 0));
        tbl.push_back(v(0, 0, 0, 4, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 2, 0, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 1, 3, 0, 0, 0, 3, 0, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 1, 1, 0, 0, 1, 0, 3, 0, 1));
        tbl.push_back(v(0, 1, 1, 0, 0, 1, 1, 4, 0, 0));
        tbl.push_back(v(0, 0, 0, 4, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 2, 0, 0, 0, 2, 0, 0));
        tbl.push_back(v(0, 1, 0, 3, 0, 0, 0, 5, 0, 0));
        tbl.push_back(v(0, 0, 0, 7, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 6'h20, 2, 0, 0, 0, 7, 0, 0));
        tbl.push_back(v(0, 0, 0, 5, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 2, 0, 2, 0, 0, 0, 9, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 6, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 1, 31, 0, 0, 31, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        foreach (tbl[i]) begin
            cyc(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].sq, tbl[i].ja, tbl[i].rq, tbl[i].rd);
            chk("tbl_upc", int'(upc), tbl[i].e_upc);
            chk("tbl_done", int'(instr_done), tbl[i].e_done);
            chk("tbl_stall", int'(stall), tbl[i].e_stall);
        end
        chk("tbl_retired", int'(retired), 6);
        chk("tbl_bus_err", int'(bus_err), 0);

        // Ready arrives on what would otherwise be the timeout cycle.
        to_memrd();
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1'b0, 2'd0, 6'd0, 3'd0, 5'd0, 1'b1, 1'b0);
        chk("pre_ready_upc", int'(upc), 3);
        cyc(1'b0, 2'd0, 6'd0, 3'd0, 5'd0, 1'b1, 1'b1);
        chk("ready_wins_upc", int'(upc), 4);
        chk("ready_wins_bus", int'(bus_err), 0);

        // Full timeout from MEMRD.
        to_memrd();
        r0 = int'(retired);
        for (int i = 0; i < TIMEOUT; i++) cyc(1'b0, 2'd0, 6'd0, 3'd4, 5'd0, 1'b1, 1'b0);
        chk("timeout_upc", int'(upc), 0);
        chk("timeout_bus", int'(bus_err), 1);
        chk("timeout_ret", int'(retired), r0);
        chk("timeout_done", int'(instr_done), 0);
        cyc(1'b0, 2'd0, 6'd0, 3'd0, 5'd0, 1'b1, 1'b0);
        chk("restall", int'(stall), 1);
        go(3'd0, 2'd0, 6'd0, 5'd0);
        chk("bus_sticky", int'(bus_err), 1);

        // Illegal dispatch.
        go(3'd2, 2'd3, 6'd0, 5'd0);
        chk("illegal_upc", int'(upc), 0);
        chk("illegal_flag", int'(dispatch_err), 1);
        chk("illegal_done", int'(instr_done), 0);
        go(3'd0, 2'd0, 6'd0, 5'd0);
        chk("disp_sticky", int'(dispatch_err), 1);

        // Reset in the middle of a wait.
        to_memrd();
        for (int i = 0; i < 5; i++) cyc(1'b0, 2'd0, 6'd0, 3'd0, 5'd0, 1'b1, 1'b0);
        cyc(1'b1, 2'd0, 6'd0, 3'd0, 5'd0, 1'b1, 1'b0);
        chk("rst_upc", int'(upc), 0);
        chk("rst_flags", {30'd0, dispatch_err, bus_err}, 0);
        chk("rst_ret", int'(retired), 0);
        to_memrd();
        for (int i = 0; i < TIMEOUT - 1; i++) cyc(1'b0, 2'd0, 6'd0, 3'd0, 5'd0, 1'b1, 1'b0);
        chk("wait_cleared_upc", int'(upc), 3);
        chk("wait_cleared_bus", int'(bus_err), 0);

        // Retired counter wrap on the 4-bit build.
        cyc(1'b1, 2'd0, 6'd0, 3'd0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) go(3'd4, 2'd0, 6'd0, 5'd0);
        chk("ret_full", int'(retired), 15);
        go(3'd4, 2'd0, 6'd0, 5'd0);
        chk("ret_wrap", int'(retired), 0);
        chk("ret_wrap_done", int'(instr_done), 1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 59) == 0), 2'($urandom), 6'($urandom), 3'($urandom), 5'($urandom),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
